// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit holding register between N requesters.
// The holder may extend its grant with lock for up to MAX_LOCK consecutive cycles.
module rr_reg_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           lock,
    input  logic [N*WIDTH-1:0]     din,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N)-1:0]   owner,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid
);

    localparam int OW = $clog2(N);
    localparam int LW = $clog2(MAX_LOCK + 1);

    logic [N-1:0]     gnt_q, gnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [LW-1:0]    lock_cnt_q, lock_cnt_d;

    logic             found;
    logic [OW-1:0]    win;
    logic             extend;

    // Winner: first requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    assign extend = (gnt_q != '0) && req[owner_q] && lock[owner_q]
                    && (lock_cnt_q < LW'(MAX_LOCK));

    always_comb begin
        gnt_d      = '0;
        owner_d    = owner_q;
        q_d        = q_q;
        q_valid_d  = 1'b0;
        ptr_d      = ptr_q;
        lock_cnt_d = '0;
        if (extend) begin
            gnt_d      = gnt_q;
            q_d        = din[owner_q*WIDTH +: WIDTH];
            q_valid_d  = 1'b1;
            lock_cnt_d = lock_cnt_q + LW'(1);
        end else if (found) begin
            gnt_d      = N'(1) << win;
            owner_d    = win;
            q_d        = din[win*WIDTH +: WIDTH];
            q_valid_d  = 1'b1;
            lock_cnt_d = LW'(1);
            ptr_d      = (win == OW'(N - 1)) ? '0 : win + OW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q      <= '0;
            owner_q    <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
        end else begin
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule
